// File: rtl/sprite_scheduler_pkg.sv
// Shared types and defaults for the sprite scheduler.
package sprite_pkg;

    // Default canvas and sprite geometry.
    localparam int DEF_NUM_SPRITES         = 32;
    localparam int DEF_NUM_FRAMES          = 512;
    localparam int DEF_CANVAS_WIDTH        = 360;
    localparam int DEF_CANVAS_HEIGHT       = 720;
    localparam int DEF_SPRITE_FRAME_WIDTH  = 64;
    localparam int DEF_SPRITE_FRAME_HEIGHT = 64;
    localparam int DEF_MAX_ANIM            = 16;
    localparam int DEF_ANIM_DIV            = 4;

    // Table fields are stored at fixed, generous widths so the struct does
    // not depend on module parameters; the top truncates on output.
    localparam int ENTRY_XW = 16;
    localparam int ENTRY_YW = 16;
    localparam int ENTRY_FW = 16;
    localparam int ENTRY_AW = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT_LOW,
        S_WAIT_HIGH
    } sched_state_t;

    typedef struct packed {
        logic                enable;
        logic [ENTRY_XW-1:0] x;
        logic [ENTRY_YW-1:0] y;
        logic [ENTRY_FW-1:0] base_frame;
        logic [ENTRY_AW-1:0] anim_len;
        logic [ENTRY_AW-1:0] phase;
    } sprite_entry_t;

    // Advance an animation phase; a length of 0 behaves as length 1.
    function automatic logic [ENTRY_AW-1:0] next_phase(
        input logic [ENTRY_AW-1:0] phase,
        input logic [ENTRY_AW-1:0] anim_len
    );
        logic [ENTRY_AW-1:0] eff_len;
        eff_len = (anim_len == '0) ? ENTRY_AW'(1) : anim_len;
        return (phase == eff_len - 1'b1) ? '0 : phase + 1'b1;
    endfunction

endpackage

// File: rtl/frame_edge_detect.sv
// Registers the video frame counter and flags any change as a new frame.
module frame_edge_detect (
    input  logic       clk_pixel,
    input  logic       sys_rst_n,
    input  logic [5:0] frame_count,
    output logic       new_frame
);

    logic [5:0] prev_frame_count;

    // One-cycle pulse the cycle after frame_count differs from its last value.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_frame_count <= '0;
            new_frame        <= 1'b0;
        end else begin
            prev_frame_count <= frame_count;
            new_frame        <= (frame_count != prev_frame_count);
        end
    end

endmodule

// File: rtl/sprite_scheduler.sv
// Walks the sprite table once per video frame, issuing one descriptor per
// drawable sprite to the renderer and stepping per-sprite animation.
module sprite_scheduler import sprite_pkg::*; #(
    parameter int NUM_SPRITES         = DEF_NUM_SPRITES,
    parameter int NUM_FRAMES          = DEF_NUM_FRAMES,
    parameter int CANVAS_WIDTH        = DEF_CANVAS_WIDTH,
    parameter int CANVAS_HEIGHT       = DEF_CANVAS_HEIGHT,
    parameter int SPRITE_FRAME_WIDTH  = DEF_SPRITE_FRAME_WIDTH,
    parameter int SPRITE_FRAME_HEIGHT = DEF_SPRITE_FRAME_HEIGHT,
    parameter int MAX_ANIM            = DEF_MAX_ANIM,
    parameter int ANIM_DIV            = DEF_ANIM_DIV
) (
    input  logic                             clk_pixel,
    input  logic                             sys_rst_n,
    input  logic [5:0]                       frame_count,
    input  logic                             wr_en,
    input  logic [$clog2(NUM_SPRITES)-1:0]   wr_index,
    input  logic                             wr_enable,
    input  logic [$clog2(CANVAS_WIDTH)-1:0]  wr_x,
    input  logic [$clog2(CANVAS_HEIGHT)-1:0] wr_y,
    input  logic [$clog2(NUM_FRAMES)-1:0]    wr_base_frame,
    input  logic [$clog2(MAX_ANIM+1)-1:0]    wr_anim_len,
    input  logic                             sprite_ready,
    output logic                             sprite_valid,
    output logic [$clog2(CANVAS_WIDTH)-1:0]  sprite_x,
    output logic [$clog2(CANVAS_HEIGHT)-1:0] sprite_y,
    output logic [$clog2(NUM_FRAMES)-1:0]    sprite_frame_number,
    output logic                             pass_done,
    output logic [7:0]                       overrun_count
);

    localparam int XW = $clog2(CANVAS_WIDTH);
    localparam int YW = $clog2(CANVAS_HEIGHT);
    localparam int FW = $clog2(NUM_FRAMES);
    localparam int IW = $clog2(NUM_SPRITES);
    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    sched_state_t  state_q, state_d;
    logic [IW:0]   idx_q, idx_d;          // one extra bit to reach "past end"
    logic [DW-1:0] div_q;
    logic          tick_q;                // current pass steps animation
    sprite_entry_t table_q [NUM_SPRITES];
    sprite_entry_t cur, new_entry;
    logic          new_frame, idx_end, skip, latch, upd_phase;

    frame_edge_detect u_edge (
        .clk_pixel   (clk_pixel),
        .sys_rst_n   (sys_rst_n),
        .frame_count (frame_count),
        .new_frame   (new_frame)
    );

    assign idx_end      = (idx_q == (IW+1)'(NUM_SPRITES));
    assign sprite_valid = (state_q == S_ISSUE);

    // Entry lookup, clip test and next-state selection. A new frame outside
    // IDLE is an overrun: the pass restarts at entry 0 without pass_done.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        latch     = 1'b0;
        upd_phase = 1'b0;
        pass_done = 1'b0;
        cur       = table_q[idx_q[IW-1:0]];
        skip      = !cur.enable
                 || (32'(cur.x) + 32'(SPRITE_FRAME_WIDTH)  > 32'(CANVAS_WIDTH))
                 || (32'(cur.y) + 32'(SPRITE_FRAME_HEIGHT) > 32'(CANVAS_HEIGHT));
        if (new_frame) begin
            idx_d   = '0;
            state_d = S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (idx_end) begin
                        pass_done = 1'b1;
                        state_d   = S_IDLE;
                    end else if (skip) begin
                        idx_d     = idx_q + 1'b1;
                        upd_phase = tick_q && cur.enable;
                    end else if (sprite_ready) begin
                        latch     = 1'b1;
                        upd_phase = tick_q;
                        state_d   = S_ISSUE;
                    end
                end
                S_ISSUE:     state_d = S_WAIT_LOW;
                S_WAIT_LOW:  if (!sprite_ready) state_d = S_WAIT_HIGH;
                S_WAIT_HIGH: begin
                    if (sprite_ready) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
                default:     state_d = S_IDLE;
            endcase
        end
    end

    // Sequencer state, animation divider, overrun counter and descriptor latch.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q             <= S_IDLE;
            idx_q               <= '0;
            div_q               <= '0;
            tick_q              <= 1'b0;
            overrun_count       <= '0;
            sprite_x            <= '0;
            sprite_y            <= '0;
            sprite_frame_number <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (new_frame) begin
                tick_q <= (32'(div_q) == 32'(ANIM_DIV - 1));
                div_q  <= (32'(div_q) == 32'(ANIM_DIV - 1)) ? '0 : div_q + 1'b1;
                if (state_q != S_IDLE && overrun_count != 8'hFF)
                    overrun_count <= overrun_count + 8'd1;
            end
            if (latch) begin
                sprite_x            <= XW'(cur.x);
                sprite_y            <= YW'(cur.y);
                sprite_frame_number <= FW'(cur.base_frame + ENTRY_FW'(cur.phase));
            end
        end
    end

    always_comb begin
        new_entry            = '0;
        new_entry.enable     = wr_enable;
        new_entry.x          = ENTRY_XW'(wr_x);
        new_entry.y          = ENTRY_YW'(wr_y);
        new_entry.base_frame = ENTRY_FW'(wr_base_frame);
        new_entry.anim_len   = ENTRY_AW'(wr_anim_len);
    end

    // Sprite table: host writes (phase cleared) take priority over the
    // animation step of the entry being fetched.
    always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < NUM_SPRITES; i++) table_q[i] <= '0;
        end else begin
            if (upd_phase)
                table_q[idx_q[IW-1:0]].phase <= next_phase(cur.phase, cur.anim_len);
            if (wr_en)
                table_q[wr_index] <= new_entry;
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Scoreboard bench for sprite_scheduler with a simple renderer model.
module tb_sprite_scheduler;

    localparam int XW = $clog2(360);
    localparam int YW = $clog2(720);
    localparam int FW = $clog2(512);
    localparam int IW = $clog2(32);
    localparam int AW = $clog2(17);

    logic          clk_pixel = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic [5:0]    frame_count = '0;
    logic          wr_en = 1'b0;
    logic [IW-1:0] wr_index = '0;
    logic          wr_enable = 1'b0;
    logic [XW-1:0] wr_x = '0;
    logic [YW-1:0] wr_y = '0;
    logic [FW-1:0] wr_base_frame = '0;
    logic [AW-1:0] wr_anim_len = '0;
    logic          sprite_ready;
    logic          sprite_valid;
    logic [XW-1:0] sprite_x;
    logic [YW-1:0] sprite_y;
    logic [FW-1:0] sprite_frame_number;
    logic          pass_done;
    logic [7:0]    overrun_count;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [FW-1:0] f;
    } desc_t;

    desc_t exp_q[$];
    int    checks = 0, errors = 0;
    int    valid_cnt = 0, pass_cnt = 0;
    int    busy_cycles = 3, busy_cnt = 0;
    logic  ready_model = 1'b1, hold_low = 1'b0, prev_valid = 1'b0;

    assign sprite_ready = ready_model & ~hold_low;

    sprite_scheduler dut (
        .clk_pixel           (clk_pixel),
        .sys_rst_n           (sys_rst_n),
        .frame_count         (frame_count),
        .wr_en               (wr_en),
        .wr_index            (wr_index),
        .wr_enable           (wr_enable),
        .wr_x                (wr_x),
        .wr_y                (wr_y),
        .wr_base_frame       (wr_base_frame),
        .wr_anim_len         (wr_anim_len),
        .sprite_ready        (sprite_ready),
        .sprite_valid        (sprite_valid),
        .sprite_x            (sprite_x),
        .sprite_y            (sprite_y),
        .sprite_frame_number (sprite_frame_number),
        .pass_done           (pass_done),
        .overrun_count       (overrun_count)
    );

    initial forever #5 clk_pixel = ~clk_pixel;

    // Renderer: accepts on valid&ready, ready drops the next cycle for busy_cycles.
    always @(posedge clk_pixel) begin
        if (sprite_valid && sprite_ready) begin
            ready_model <= 1'b0;
            busy_cnt    <= busy_cycles;
        end else if (!ready_model) begin
            if (busy_cnt <= 1) ready_model <= 1'b1;
            else               busy_cnt    <= busy_cnt - 1;
        end
    end

    // Monitor: pop and compare each descriptor, count pass_done pulses.
    always @(negedge clk_pixel) begin
        desc_t got, e;
        if (sprite_valid) begin
            valid_cnt++;
            checks++;
            if (prev_valid) begin
                errors++;
                $display("FAIL valid_width: valid high 2 cycles, required 1");
            end
            got = '{x: sprite_x, y: sprite_y, f: sprite_frame_number};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_desc: got x=%0d y=%0d f=%0d, required none",
                         got.x, got.y, got.f);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL desc: got x=%0d y=%0d f=%0d, required x=%0d y=%0d f=%0d",
                             got.x, got.y, got.f, e.x, e.y, e.f);
                end
            end
        end
        if (pass_done) pass_cnt++;
        prev_valid = sprite_valid;
    end

    function automatic desc_t mk(input int x, input int y, input int f);
        mk = '{x: XW'(x), y: YW'(y), f: FW'(f)};
    endfunction

    task automatic apply_reset();
        @(negedge clk_pixel);
        sys_rst_n   = 1'b0;
        frame_count = '0;
        wr_en       = 1'b0;
        hold_low    = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk_pixel);
        sys_rst_n = 1'b1;
    endtask

    task automatic write_entry(input int idx, input int en, input int x, input int y,
                               input int base, input int len);
        @(negedge clk_pixel);
        wr_en         = 1'b1;
        wr_index      = IW'(idx);
        wr_enable     = (en != 0);
        wr_x          = XW'(x);
        wr_y          = YW'(y);
        wr_base_frame = FW'(base);
        wr_anim_len   = AW'(len);
        @(negedge clk_pixel);
        wr_en = 1'b0;
    endtask

    task automatic bump_frame();
        @(negedge clk_pixel);
        frame_count = frame_count + 6'd1;
    endtask

    task automatic wait_pass(input int target, input int maxc, input string name);
        for (int i = 0; i < maxc && pass_cnt < target; i++) @(negedge clk_pixel);
        checks++;
        if (pass_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: pass_done count %0d, required %0d", name, pass_cnt, target);
        end
    endtask

    task automatic wait_valid(input int target, input int maxc, input string name);
        for (int i = 0; i < maxc && valid_cnt < target; i++) @(negedge clk_pixel);
        checks++;
        if (valid_cnt < target) begin
            errors++;
            $display("FAIL %s_timeout: valid count %0d, required %0d", name, valid_cnt, target);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(negedge clk_pixel);
        checks++;
        if ({sprite_valid, pass_done, overrun_count, sprite_x, sprite_y, sprite_frame_number} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: v=%b pd=%b ov=%0d x=%0d y=%0d f=%0d, required all 0",
                     sprite_valid, pass_done, overrun_count, sprite_x, sprite_y, sprite_frame_number);
        end
        sys_rst_n = 1'b1;
        repeat (3) @(negedge clk_pixel);
        checks++;
        if (sprite_valid !== 1'b0 || pass_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: v=%b pd=%b, required 0 0", sprite_valid, pass_done);
        end
    endtask

    task automatic test_anim();
        int pc;
        apply_reset();
        write_entry(5, 1, 20, 30, 8, 3);
        write_entry(6, 1, 40, 50, 20, 0);   // length 0 behaves as 1
        for (int p = 0; p < 16; p++) begin
            pc = pass_cnt;
            exp_q.push_back(mk(20, 30, 8 + ((p / 4) % 3)));
            exp_q.push_back(mk(40, 50, 20));
            bump_frame();
            wait_pass(pc + 1, 500, "anim");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL anim_drain: %0d descriptors missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_basic();
        int vc, pc;
        apply_reset();
        write_entry(0, 1, 10, 20, 5, 1);
        write_entry(2, 1, 100, 300, 40, 1);
        vc = valid_cnt; pc = pass_cnt;
        exp_q.push_back(mk(10, 20, 5));
        exp_q.push_back(mk(100, 300, 40));
        bump_frame();
        wait_pass(pc + 1, 500, "basic");
        checks++;
        if (valid_cnt - vc != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: %0d descriptors (%0d left), required 2 (0 left)",
                     valid_cnt - vc, exp_q.size());
        end
    endtask

    task automatic test_clip();
        int vc, pc;
        write_entry(1, 1, 300, 0, 11, 1);   // 300+64 > 360
        write_entry(3, 1, 0, 700, 12, 1);   // 700+64 > 720
        write_entry(4, 1, 296, 656, 7, 1);  // exactly touches both edges
        vc = valid_cnt; pc = pass_cnt;
        exp_q.push_back(mk(10, 20, 5));
        exp_q.push_back(mk(100, 300, 40));
        exp_q.push_back(mk(296, 656, 7));
        bump_frame();
        wait_pass(pc + 1, 500, "clip");
        checks++;
        if (valid_cnt - vc != 3 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL clip_count: %0d descriptors (%0d left), required 3 (0 left)",
                     valid_cnt - vc, exp_q.size());
        end
    endtask

    task automatic test_stall();
        int vc, pc;
        apply_reset();
        write_entry(0, 1, 10, 20, 5, 1);
        hold_low = 1'b1;
        vc = valid_cnt; pc = pass_cnt;
        exp_q.push_back(mk(10, 20, 5));
        bump_frame();
        repeat (20) @(negedge clk_pixel);
        checks++;
        if (valid_cnt != vc || pass_cnt != pc) begin
            errors++;
            $display("FAIL stall: valids %0d passes %0d, required 0 0", valid_cnt - vc, pass_cnt - pc);
        end
        hold_low = 1'b0;
        wait_pass(pc + 1, 500, "stall");
        checks++;
        if (valid_cnt - vc != 1) begin
            errors++;
            $display("FAIL stall_release: %0d valids, required 1", valid_cnt - vc);
        end
    endtask

    task automatic test_overrun();
        int vc, pc;
        apply_reset();
        busy_cycles = 5000;
        for (int i = 0; i < 32; i++) write_entry(i, 1, i, i, i, 1);
        vc = valid_cnt; pc = pass_cnt;
        for (int i = 0; i < 3; i++) exp_q.push_back(mk(i, i, i));
        bump_frame();
        wait_valid(vc + 3, 12000, "overrun_pre");
        repeat (100) @(negedge clk_pixel);
        checks++;
        if (overrun_count !== 8'd0) begin
            errors++;
            $display("FAIL overrun_pre: count %0d, required 0", overrun_count);
        end
        for (int i = 0; i < 32; i++) exp_q.push_back(mk(i, i, i));
        bump_frame();
        busy_cycles = 2;
        repeat (10) @(negedge clk_pixel);
        checks++;
        if (overrun_count !== 8'd1 || pass_cnt != pc) begin
            errors++;
            $display("FAIL overrun_abort: count %0d passes %0d, required 1 0", overrun_count, pass_cnt - pc);
        end
        wait_pass(pc + 1, 8000, "overrun_restart");
        checks++;
        if (exp_q.size() != 0 || overrun_count !== 8'd1) begin
            errors++;
            $display("FAIL overrun_restart: %0d left, count %0d, required 0 left, count 1",
                     exp_q.size(), overrun_count);
        end
        busy_cycles = 3;
    endtask

    task automatic test_overrun_saturate();
        int pc;
        apply_reset();
        write_entry(0, 1, 10, 20, 5, 1);
        hold_low = 1'b1;
        bump_frame();
        repeat (2) @(negedge clk_pixel);
        repeat (10) bump_frame();
        repeat (3) @(negedge clk_pixel);
        checks++;
        if (overrun_count !== 8'd10) begin
            errors++;
            $display("FAIL overrun_ten: count %0d, required 10", overrun_count);
        end
        repeat (250) bump_frame();
        repeat (3) @(negedge clk_pixel);
        checks++;
        if (overrun_count !== 8'd255) begin
            errors++;
            $display("FAIL overrun_sat: count %0d, required 255", overrun_count);
        end
        pc = pass_cnt;
        exp_q.push_back(mk(10, 20, 5));
        hold_low = 1'b0;
        wait_pass(pc + 1, 500, "overrun_sat");
    endtask

    task automatic test_reset_mid();
        int vc, pc;
        apply_reset();
        busy_cycles = 50;
        write_entry(0, 1, 10, 20, 5, 1);
        write_entry(1, 1, 30, 40, 6, 1);
        exp_q.push_back(mk(10, 20, 5));
        exp_q.push_back(mk(30, 40, 6));
        vc = valid_cnt;
        bump_frame();
        wait_valid(vc + 1, 200, "rstmid_pre");
        repeat (5) @(negedge clk_pixel);
        #2 sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({sprite_valid, pass_done, overrun_count, sprite_x, sprite_y, sprite_frame_number} !== '0) begin
            errors++;
            $display("FAIL rstmid_async: v=%b pd=%b ov=%0d x=%0d y=%0d f=%0d, required all 0",
                     sprite_valid, pass_done, overrun_count, sprite_x, sprite_y, sprite_frame_number);
        end
        exp_q.delete();
        frame_count = '0;
        repeat (2) @(negedge clk_pixel);
        sys_rst_n = 1'b1;
        busy_cycles = 3;
        vc = valid_cnt; pc = pass_cnt;
        bump_frame();
        wait_pass(pc + 1, 500, "rstmid_empty");
        checks++;
        if (valid_cnt != vc) begin
            errors++;
            $display("FAIL rstmid_empty: %0d valids, required 0", valid_cnt - vc);
        end
        write_entry(0, 1, 50, 60, 9, 1);
        exp_q.push_back(mk(50, 60, 9));
        pc = pass_cnt;
        bump_frame();
        wait_pass(pc + 1, 500, "rstmid_rewrite");
        checks++;
        if (valid_cnt - vc != 1) begin
            errors++;
            $display("FAIL rstmid_rewrite: %0d valids, required 1", valid_cnt - vc);
        end
    endtask

    initial begin
        test_reset();
        test_anim();
        test_basic();
        test_clip();
        test_stall();
        test_overrun();
        test_overrun_saturate();
        test_reset_mid();
        repeat (5) @(negedge clk_pixel);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

- Sits directly upstream of the HDMI sprite renderer.
- Holds a table of game sprites and walks the table once per video frame. For each drawable sprite it issues one sprite descriptor (x, y, frame number) across the renderer's `sprite_valid`/`sprite_ready` handshake.
- Also sequences per-sprite animation and drops sprites the renderer cannot clip.

## Interface
Parameters:
- `NUM_SPRITES`, 32: table entries.
- `NUM_FRAMES`, 512: total spritesheet frames.
- `CANVAS_WIDTH`, 360: canvas width in pixels.
- `CANVAS_HEIGHT`, 720: canvas height in pixels.
- `SPRITE_FRAME_WIDTH`, 64: sprite frame width in pixels.
- `SPRITE_FRAME_HEIGHT`, 64: sprite frame height in pixels.
- `MAX_ANIM`, 16: maximum animation length in frames.
- `ANIM_DIV`, 4: video frames per animation step.

Ports (XW=$clog2(CANVAS_WIDTH), YW=$clog2(CANVAS_HEIGHT), FW=$clog2(NUM_FRAMES), IW=$clog2(NUM_SPRITES), AW=$clog2(MAX_ANIM+1)):
- `clk_pixel`  in  1  pixel clock; the only clock.
- `sys_rst_n`  in  1  reset; asynchronous assert, active-low.
- `frame_count`  in  6  video frame counter; any change starts a pass.
- `wr_en`  in  1  table write strobe.
- `wr_index`  in  IW  entry to write.
- `wr_enable`  in  1  entry drawable.
- `wr_x`  in  XW  sprite x position.
- `wr_y`  in  YW  sprite y position.
- `wr_base_frame`  in  FW  first frame number of the animation.
- `wr_anim_len`  in  AW  animation length in frames; 0 is treated as 1.
- `sprite_ready`  in  1  renderer idle.
- `sprite_valid`  out  1  descriptor strobe, one cycle wide.
- `sprite_x`  out  XW  descriptor x.
- `sprite_y`  out  YW  descriptor y.
- `sprite_frame_number`  out  FW  descriptor frame number.
- `pass_done`  out  1  one-cycle pulse at the end of a completed pass.
- `overrun_count`  out  8  saturating count of aborted passes.

## Operation
- Table entry fields: enable, x, y, base_frame, anim_len, phase.
  - A write sets every field except phase.
  - Phase resets to 0 on any write.
- State machine: IDLE, FETCH, ISSUE, WAIT_LOW, WAIT_HIGH.
  - IDLE: on `frame_count != prev_frame_count`, set idx=0, advance the animation tick counter, go to FETCH.
  - FETCH: latch entry idx. The entry is skipped (idx+1, stay in FETCH) if any of:
    - enable=0;
    - x+SPRITE_FRAME_WIDTH > CANVAS_WIDTH;
    - y+SPRITE_FRAME_HEIGHT > CANVAS_HEIGHT.
  - FETCH, no skip: wait for `sprite_ready`=1, then go to ISSUE.
  - FETCH, idx past NUM_SPRITES-1: pulse `pass_done`, go to IDLE.
  - ISSUE: drive `sprite_valid`=1 for exactly one cycle with the latched fields.
    - Frame number = (base_frame + phase) truncated to FW bits.
    - Go to WAIT_LOW.
  - WAIT_LOW: wait for `sprite_ready`=0, meaning the renderer has accepted and its ready lags one cycle. Go to WAIT_HIGH.
  - WAIT_HIGH: wait for `sprite_ready`=1, then idx+1, go to FETCH.
- Animation:
  - The tick is asserted on a pass start when the frame divider reaches ANIM_DIV-1. The divider then wraps to 0.
  - On tick passes, every enabled entry, skipped or not, updates phase at FETCH: phase = (phase == eff_len-1) ? 0 : phase+1, where eff_len = max(anim_len, 1).
- Overrun: if `frame_count` changes while not in IDLE:
  - abort the pass;
  - increment `overrun_count`, saturating at 255;
  - restart at idx=0 with no `pass_done`.
  - An abort during ISSUE still completes the one-cycle valid pulse; the restart takes effect on the next cycle.
- Write to the entry currently latched: the latched copy is used for the current descriptor, and the new value is used from the next pass.

## Timing
- Reset values:
  - `sprite_valid`=0, `pass_done`=0, `overrun_count`=0;
  - `sprite_x`=0, `sprite_y`=0, `sprite_frame_number`=0;
  - state IDLE;
  - all entries enable=0, phase=0;
  - `prev_frame_count`=0;
  - divider=0.
- Latency:
  - The `frame_count` change is seen by an edge register, giving 1 cycle to leave IDLE.
  - FETCH to ISSUE takes 1 cycle when `sprite_ready`=1.
  - Per issued sprite, the minimum is 3 cycles plus the renderer busy time.
  - A skipped entry costs 1 cycle.
- Descriptor outputs hold their values after `sprite_valid` falls.
- Reset mid-pass:
  - Reset clears state immediately.
  - The renderer may still be busy; the next pass waits on `sprite_ready` in FETCH.

## Structure
- Package `sprite_pkg`:
  - state enum `sched_state_t`;
  - struct `sprite_entry_t` (enable, x, y, base_frame, anim_len, phase);
  - default canvas and sprite-size constants.
- The table is a register array, because phase needs a per-entry read-modify-write and NUM_SPRITES is small.
- One sub-module, `frame_edge_detect`: registers `frame_count` and outputs a new-frame pulse.

## Test plan
- Entries 0 and 2 enabled at (10,20) frame 5 and (100,300) frame 40; renderer model ready. Change `frame_count` → exactly two valid pulses, in order (10,20,5) then (100,300,40), then `pass_done`.
- Entry with x=300 (300+64 > 360) or y=700 → no descriptor issued; `pass_done` still pulses.
- ANIM_DIV=4, base=8, anim_len=3 → frame numbers over passes 0..15: 8 ×4, 9 ×4, 10 ×4, 8 ×4.
- Renderer busy 5000 cycles per sprite, 32 sprites, `frame_count` change mid-pass → `overrun_count`=1, pass restarts at entry 0, no `pass_done`.
- `sprite_ready` held low → scheduler stalls in FETCH with `sprite_valid`=0. Release → a single valid pulse, never two per acceptance.
- Assert `sys_rst_n`=0 during WAIT_HIGH → all outputs go to 0 asynchronously and no descriptors are issued until the table is rewritten.
